signed_calc_seq_v: RTL
======================

# signed_calc_seq_v

Multi-cycle sequencer that computes F = 6·A − 11·B on signed 5-bit operands. It time-shares one 10-bit ripple add/subtract chain built from `full_adder_v` cells instead of instantiating separate multiplier and subtractor adder arrays. It sits between an operand source (switches or a host FSM) and the result display. It uses a start/busy/done handshake and delivers a 9-bit signed result with saturation and an overflow flag.

## Interface
- No parameters. Widths are fixed by the 6X−11Y datapath.
- `i_clk`  in  1  single system clock; all state changes on the rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_start`  in  1  request pulse or level; sampled only in IDLE.
- `i_as`  in  5  signed operand A; captured on the accepted start.
- `i_bs`  in  5  signed operand B; captured on the accepted start.
- `o_busy`  out  1  high from the cycle after an accepted start through the DONE cycle.
- `o_done`  out  1  one-cycle pulse marking the cycle in which `o_fs` and `o_ovf` become valid.
- `o_fs`  out  9  signed result, saturated to the range −256..255; held until the next `o_done`.
- `o_ovf`  out  1  set when the true result lies outside −256..255; held with `o_fs`.

## Operation
- FSM states, in order: IDLE, ADD2A, ADD4A, SUB1B, SUB2B, SUB8B, DONE.
- **IDLE:**
  - If `i_start` = 1: latch A and B, sign-extended to 10 bits; clear the accumulator `acc` (10-bit signed) to 0; go to ADD2A.
  - Otherwise stay in IDLE.
- **Compute states:** each state performs one pass through the shared adder and then advances to the next state.
  - ADD2A: acc += A<<1
  - ADD4A: acc += A<<2
  - SUB1B: acc −= B
  - SUB2B: acc −= B<<1
  - SUB8B: acc −= B<<3, and the final value is written to the output registers.
- **Subtraction:** done as acc + ~operand + 1. The add/sub select drives both the operand XOR and the chain's carry-in; no separate negation logic.
- **Arithmetic range:** the true result spans −261 (A=−16, B=15) to 266 (A=15, B=−16). The 10-bit accumulator never overflows internally, and the final carry-out is discarded.
- **Saturation at the end of SUB8B:**
  - acc > 255: `o_fs` = 255, `o_ovf` = 1.
  - acc < −256: `o_fs` = −256, `o_ovf` = 1.
  - Otherwise `o_fs` = acc[8:0], `o_ovf` = 0.
- **DONE:** `o_done` = 1 for this one cycle; next state is IDLE.
  - A start is not accepted in DONE; the earliest restart is sampled in the following IDLE cycle.
- **Start while busy:** `i_start` outside IDLE is ignored. Changes on `i_as`/`i_bs` after capture do not affect the running operation.
- **Held start:** a start held high continuously restarts every 7 cycles. This is legal.

## Timing
- **Reset:** `i_rst` = 1 at a rising edge forces, after that edge:
  - state = IDLE, `acc` = 0
  - `o_busy` = 0, `o_done` = 0, `o_fs` = 0, `o_ovf` = 0
- **Reset priority:** reset overrides everything, including mid-operation. An aborted operation produces no `o_done`, and the previous `o_fs` is cleared to 0.
- **Latency:** start sampled at edge k → `o_busy` = 1 from edge k to edge k+6 → `o_fs`, `o_ovf` valid and `o_done` = 1 after edge k+6 → `o_busy`, `o_done` = 0 after edge k+7.
- **Throughput:** one result per 7 cycles.
- **Output style:** all outputs are registered; no combinational path from inputs to outputs.

## Structure
- **Shared header** `calc_defs.vh`: state encodings (3-bit, binary), the accumulator width (10) and the result width (9). Any later controller for this datapath reuses it.
- **Sub-module** `add_sub_10_v`: a 10-bit ripple chain of `full_adder_v` cells.
  - Inputs: a, b, i_sub. Output: sum.
  - Internally XORs b with i_sub and uses i_sub as the carry-in.
  - Purely combinational; the sequencer holds the one instance.
- **Top level** contains: FSM, operand registers, shift-select mux (A<<1, A<<2, B, B<<1, B<<3), accumulator, saturation logic and output registers.

## Test plan
- A=3, B=1, start pulse → `o_done` 7 cycles after the start edge, `o_fs` = 7, `o_ovf` = 0. `o_busy` high for exactly 7 cycles.
- A=−16, B=15 → `o_fs` = −256 (9'h100), `o_ovf` = 1. Then A=15, B=−16 → `o_fs` = 255, `o_ovf` = 1.
- A=−5, B=−3 → `o_fs` = 3. A=0, B=0 → `o_fs` = 0. Exhaustive sweep of all 1024 operand pairs against the 6A−11B model, with saturation applied.
- Start A=2, B=1; at cycle 3 pulse start with A=7, B=7 and change the inputs → result = 1 from the original operands; second start ignored; no extra `o_done`.
- Start, then assert `i_rst` during SUB1B → next cycle: all outputs 0, state IDLE; no `o_done` follows. A new start then completes normally.
- `i_start` held high for 21 cycles with A=1, B=0 → exactly 3 `o_done` pulses, each with `o_fs` = 6, spaced 7 cycles apart.

Source files
------------

// File: rtl/signed_calc_seq_v_pkg.sv
// Shared definitions for the 6A-11B sequencer family:
// state encodings, datapath widths and small helpers.
package signed_calc_seq_v_pkg;

  localparam int ACC_W = 10;
  localparam int RES_W = 9;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADD2A = 3'd1,
    S_ADD4A = 3'd2,
    S_SUB1B = 3'd3,
    S_SUB2B = 3'd4,
    S_SUB8B = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  function automatic logic [ACC_W-1:0] sext5(
    input logic [4:0] v
  );
    return {{(ACC_W-5){v[4]}}, v};
  endfunction

  // Returns {ovf, fs}: clamps the accumulator to -256..255.
  function automatic logic [RES_W:0] sat9(
    input logic signed [ACC_W-1:0] acc
  );
    logic [RES_W:0] r;
    if (acc > 10'sd255)
      r = {1'b1, 9'h0FF};
    else if (acc < -10'sd256)
      r = {1'b1, 9'h100};
    else
      r = {1'b0, acc[RES_W-1:0]};
    return r;
  endfunction

endpackage

// File: rtl/signed_calc_seq_v_add_sub.sv
// Shared 10-bit ripple add/subtract chain and its full-adder cell.
// Ports: a, b (10b), i_sub (1 = a - b), sum (10b).
module full_adder_v (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module add_sub_10_v
  import signed_calc_seq_v_pkg::*;
(
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  input  logic             i_sub,
  output logic [ACC_W-1:0] sum
);
  logic [ACC_W-1:0] w_bx;
  logic [ACC_W-1:0] w_c;

  // Subtract as a + ~b + 1: i_sub inverts b and feeds the carry-in.
  assign w_bx   = b ^ {ACC_W{i_sub}};
  assign w_c[0] = i_sub;

  for (genvar g = 0; g < ACC_W - 1; g++) begin : g_fa
    full_adder_v u_fa (
      .a    (a[g]),
      .b    (w_bx[g]),
      .cin  (w_c[g]),
      .s    (sum[g]),
      .cout (w_c[g+1])
    );
  end

  // Top bit: the carry out of the chain is discarded,
  // so only the sum half of the cell is built.
  assign sum[ACC_W-1] = a[ACC_W-1] ^ w_bx[ACC_W-1]
                      ^ w_c[ACC_W-1];
endmodule

// File: rtl/signed_calc_seq_v.sv
// Sequencer computing F = 6A - 11B over one shared adder.
// Ports: i_clk, i_rst, i_start, i_as, i_bs -> o_busy, o_done, o_fs, o_ovf.
module signed_calc_seq_v
  import signed_calc_seq_v_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [4:0]       i_as,
  input  logic [4:0]       i_bs,
  output logic             o_busy,
  output logic             o_done,
  output logic [RES_W-1:0] o_fs,
  output logic             o_ovf
);
  state_t r_state, w_next;

  logic [ACC_W-1:0] r_a, r_b, r_acc;
  logic [ACC_W-1:0] w_opnd, w_sum;
  logic             w_sub, w_step, w_accept;
  logic [RES_W:0]   w_sat;
  logic             r_busy, r_done, r_ovf;
  logic [RES_W-1:0] r_fs;

  always_comb begin
    w_next = r_state;
    w_opnd = '0;
    w_sub  = 1'b0;
    w_step = 1'b0;
    unique case (r_state)
      S_IDLE:
        if (i_start) w_next = S_ADD2A;
      S_ADD2A: begin
        w_opnd = r_a << 1;
        w_step = 1'b1;
        w_next = S_ADD4A;
      end
      S_ADD4A: begin
        w_opnd = r_a << 2;
        w_step = 1'b1;
        w_next = S_SUB1B;
      end
      S_SUB1B: begin
        w_opnd = r_b;
        w_sub  = 1'b1;
        w_step = 1'b1;
        w_next = S_SUB2B;
      end
      S_SUB2B: begin
        w_opnd = r_b << 1;
        w_sub  = 1'b1;
        w_step = 1'b1;
        w_next = S_SUB8B;
      end
      S_SUB8B: begin
        w_opnd = r_b << 3;
        w_sub  = 1'b1;
        w_step = 1'b1;
        w_next = S_DONE;
      end
      S_DONE:
        w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  assign w_accept = (r_state == S_IDLE) && i_start;
  assign w_sat    = sat9(r_acc);

  add_sub_10_v u_addsub (
    .a     (r_acc),
    .b     (w_opnd),
    .i_sub (w_sub),
    .sum   (w_sum)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_fs    <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      // Busy covers the accept edge through the edge leaving DONE.
      r_busy  <= (r_state != S_IDLE) || i_start;
      r_done  <= (r_state == S_DONE);
      if (w_accept) begin
        r_a   <= sext5(i_as);
        r_b   <= sext5(i_bs);
        r_acc <= '0;
      end else if (w_step) begin
        r_acc <= w_sum;
      end
      if (r_state == S_DONE) begin
        r_fs  <= w_sat[RES_W-1:0];
        r_ovf <= w_sat[RES_W];
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_fs   = r_fs;
  assign o_ovf  = r_ovf;
endmodule
